rams_tdp_arbiter: RTL and testbench

Arbiter and init sequencer for the hybrid tree's true dual-port, write-first block RAM. After reset it clears the RAM using both ports. It then shares the two RAM ports among `NUM_REQ` requesters, granting up to two requests per cycle with round-robin fairness. It resolves same-address hazards and returns per-requester responses one cycle after acceptance. It sits between the tree-level controllers and the RAM instance; the RAM's `clka` and `clkb` are both tied to `clk`.

---
 rtl/rams_tdp_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_rams_tdp_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rams_tdp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rams_tdp_arbiter
// Brief    : Zero-fill sequencer and two-port round-robin arbiter in front of
//            a true dual-port, write-first block RAM (clka = clkb = clk).
// Revision : 1.0 - initial release
// ============================================================================
module rams_tdp_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 1024,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [NUM_REQ-1:0]         rsp_err,
    output logic [NUM_REQ*WIDTH-1:0]   rsp_rdata,
    output logic                       init_done,
    output logic                       ram_ena,
    output logic                       ram_wea,
    output logic                       ram_enb,
    output logic                       ram_web,
    output logic [31:0]                ram_addra,
    output logic [31:0]                ram_addrb,
    output logic [WIDTH-1:0]           ram_dia,
    output logic [WIDTH-1:0]           ram_dib,
    input  logic [WIDTH-1:0]           ram_doa,
    input  logic [WIDTH-1:0]           ram_dob
);

    localparam int c_iw          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_sw          = c_iw + 1;
    localparam int c_init_cycles = (DEPTH + 1) / 2;
    localparam int c_kw          = (c_init_cycles > 1) ? $clog2(c_init_cycles) : 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_init_cycles - 1);
    localparam bit c_depth_odd   = (DEPTH % 2) != 0;

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]        r_state;
    logic [c_kw-1:0]   r_k;
    logic [c_iw-1:0]   r_rr;

    logic              r_a_vld;
    logic [c_iw-1:0]   r_a_idx;
    logic              r_a_err;
    logic              r_b_vld;
    logic [c_iw-1:0]   r_b_idx;
    logic              r_b_err;

    logic [31:0]       w_addr    [NUM_REQ];
    logic [WIDTH-1:0]  w_wdata   [NUM_REQ];
    logic [NUM_REQ-1:0] w_inrange;

    logic              w_run;
    logic              w_a_hit;
    logic [c_iw-1:0]   w_a_idx;
    logic              w_b_hit;
    logic [c_iw-1:0]   w_b_idx;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_addr[g]    = req_addr[32*g +: 32];
            assign w_wdata[g]   = req_wdata[WIDTH*g +: WIDTH];
            assign w_inrange[g] = (w_addr[g] < 32'(DEPTH));
        end
    endgenerate

    assign w_run     = (r_state == c_st_run) && !rst;
    assign init_done = (r_state == c_st_run) && !rst;

    function automatic logic [c_iw-1:0] f_next(input logic [c_iw-1:0] idx);
        logic [c_sw-1:0] n;
        n = {1'b0, idx} + c_sw'(1);
        if (n >= c_sw'(NUM_REQ)) begin
            n = '0;
        end
        return n[c_iw-1:0];
    endfunction

    // Cyclic scan from rr: first valid takes port A, next non-conflicting valid takes port B.
    always_comb begin
        logic [c_sw-1:0] v_scan;
        logic [c_iw-1:0] v_idx;
        w_a_hit = 1'b0;
        w_a_idx = '0;
        w_b_hit = 1'b0;
        w_b_idx = '0;
        v_scan  = '0;
        v_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_scan = {1'b0, r_rr} + c_sw'(i);
            if (v_scan >= c_sw'(NUM_REQ)) begin
                v_scan = v_scan - c_sw'(NUM_REQ);
            end
            v_idx = v_scan[c_iw-1:0];
            if (w_run && req_valid[v_idx]) begin
                if (!w_a_hit) begin
                    w_a_hit = 1'b1;
                    w_a_idx = v_idx;
                end else if (!w_b_hit &&
                             !((w_addr[v_idx] == w_addr[w_a_idx]) &&
                               (req_we[v_idx] || req_we[w_a_idx]))) begin
                    w_b_hit = 1'b1;
                    w_b_idx = v_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_a_hit) begin
            req_ready[w_a_idx] = 1'b1;
        end
        if (w_b_hit) begin
            req_ready[w_b_idx] = 1'b1;
        end
    end

    // Out-of-range grants keep their slot but never touch the RAM.
    always_comb begin
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dia   = '0;
        ram_enb   = 1'b0;
        ram_web   = 1'b0;
        ram_addrb = '0;
        ram_dib   = '0;
        if (!rst) begin
            if (r_state == c_st_init) begin
                ram_ena   = 1'b1;
                ram_wea   = 1'b1;
                ram_addra = 32'({r_k, 1'b0});
                ram_enb   = !(c_depth_odd && (r_k == c_k_last));
                ram_web   = !(c_depth_odd && (r_k == c_k_last));
                ram_addrb = 32'({r_k, 1'b1});
            end else begin
                if (w_a_hit) begin
                    ram_ena   = w_inrange[w_a_idx];
                    ram_wea   = w_inrange[w_a_idx] && req_we[w_a_idx];
                    ram_addra = w_addr[w_a_idx];
                    ram_dia   = w_wdata[w_a_idx];
                end
                if (w_b_hit) begin
                    ram_enb   = w_inrange[w_b_idx];
                    ram_web   = w_inrange[w_b_idx] && req_we[w_b_idx];
                    ram_addrb = w_addr[w_b_idx];
                    ram_dib   = w_wdata[w_b_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_ON_RESET ? c_st_init : c_st_run;
            r_k     <= '0;
            r_rr    <= '0;
            r_a_vld <= 1'b0;
            r_a_idx <= '0;
            r_a_err <= 1'b0;
            r_b_vld <= 1'b0;
            r_b_idx <= '0;
            r_b_err <= 1'b0;
        end else begin
            r_a_vld <= w_a_hit;
            r_a_idx <= w_a_idx;
            r_a_err <= w_a_hit && !w_inrange[w_a_idx];
            r_b_vld <= w_b_hit;
            r_b_idx <= w_b_idx;
            r_b_err <= w_b_hit && !w_inrange[w_b_idx];

            if (r_state == c_st_init) begin
                if (r_k == c_k_last) begin
                    r_state <= c_st_run;
                end else begin
                    r_k <= r_k + c_kw'(1);
                end
            end

            if (w_b_hit) begin
                r_rr <= f_next(w_b_idx);
            end else if (w_a_hit) begin
                r_rr <= f_next(w_a_idx);
            end
        end
    end

    // RAM outputs are registered, so the grant registered last cycle selects this cycle's data.
    always_comb begin
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_rdata = '0;
        if (!rst) begin
            if (r_a_vld) begin
                rsp_valid[r_a_idx] = 1'b1;
                rsp_err[r_a_idx]   = r_a_err;
                if (!r_a_err) begin
                    rsp_rdata[int'(r_a_idx)*WIDTH +: WIDTH] = ram_doa;
                end
            end
            if (r_b_vld) begin
                rsp_valid[r_b_idx] = 1'b1;
                rsp_err[r_b_idx]   = r_b_err;
                if (!r_b_err) begin
                    rsp_rdata[int'(r_b_idx)*WIDTH +: WIDTH] = ram_dob;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rams_tdp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rams_tdp_arbiter
// Brief    : Scoreboard bench for rams_tdp_arbiter with a write-first TDP RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rams_tdp_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 1024;
    localparam int AW      = 10;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ*32-1:0]    req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_err;
    logic [NUM_REQ*WIDTH-1:0] rsp_rdata;
    logic                     init_done;
    logic                     ram_ena, ram_wea, ram_enb, ram_web;
    logic [31:0]              ram_addra, ram_addrb;
    logic [WIDTH-1:0]         ram_dia, ram_dib, ram_doa, ram_dob;

    rams_tdp_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_enb(ram_enb), .ram_web(ram_web),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dia(ram_dia), .ram_dib(ram_dib),
        .ram_doa(ram_doa), .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    // Write-first true dual-port RAM with registered outputs
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) begin
                mem[ram_addra[AW-1:0]] <= ram_dia;
                ram_doa <= ram_dia;
            end else begin
                ram_doa <= mem[ram_addra[AW-1:0]];
            end
        end
        if (ram_enb) begin
            if (ram_web) begin
                mem[ram_addrb[AW-1:0]] <= ram_dib;
                ram_dob <= ram_dib;
            end else begin
                ram_dob <= mem[ram_addrb[AW-1:0]];
            end
        end
    end

    typedef struct {
        int               id;
        logic             err;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t             sbq [$];
    logic [WIDTH-1:0] exp_data [NUM_REQ];
    logic             exp_err  [NUM_REQ];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    logic             s_ena, s_wea, s_enb, s_web;
    logic [31:0]      s_addrb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ed, input logic ee);
        req_valid[i]               = 1'b1;
        req_we[i]                  = we;
        req_addr[i*32 +: 32]       = a;
        req_wdata[i*WIDTH +: WIDTH] = d;
        exp_data[i]                = ed;
        exp_err[i]                 = ee;
    endtask

    // One cycle: sample acceptance mid-cycle, push expectations, realign after the edge.
    task automatic run_cycle(output logic [NUM_REQ-1:0] acc);
        exp_t e;
        @(negedge clk);
        acc     = req_valid & req_ready;
        s_ena   = ram_ena;
        s_wea   = ram_wea;
        s_enb   = ram_enb;
        s_web   = ram_web;
        s_addrb = ram_addrb;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                e.id = i; e.err = exp_err[i]; e.data = exp_data[i]; e.cyc = cyc;
                sbq.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic [NUM_REQ-1:0] acc;
        req_valid = '0;
        for (int i = 0; i < n; i++) run_cycle(acc);
    endtask

    // Called one step after the edge that released rst; returns aligned in RUN.
    task automatic wait_init(input string nm);
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (init_done) break;
            if (n == 0) begin
                check({nm, "_ready0"}, 64'(req_ready), 64'(0));
                check({nm, "_rsp0"}, 64'(rsp_valid), 64'(0));
                check({nm, "_porta0"}, 64'({ram_ena, ram_wea, ram_addra, ram_dia}), 64'({2'b11, 32'd0, 16'h0}));
                check({nm, "_portb0"}, 64'({ram_enb, ram_web, ram_addrb, ram_dib}), 64'({2'b11, 32'd1, 16'h0}));
                req_valid = '0;
            end
            if (n == DEPTH/2 - 1) begin
                check({nm, "_portalast"}, 64'({ram_ena, ram_addra}), 64'({1'b1, 32'd1022}));
                check({nm, "_portblast"}, 64'({ram_enb, ram_addrb}), 64'({1'b1, 32'd1023}));
            end
            n++;
            @(posedge clk); #1;
        end
        check({nm, "_len"}, 64'(n), 64'(DEPTH/2));
        @(posedge clk); #1;
    endtask

    // Monitor: every presented response is matched against the scoreboard.
    exp_t m_e;
    int   m_idx;
    bit   m_found;
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            n_tests++;
            if (rsp_valid[i]) begin
                m_found = 1'b0;
                m_idx   = 0;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (!m_found && sbq[j].id == i) begin
                        m_found = 1'b1;
                        m_idx   = j;
                    end
                end
                if (!m_found) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected[%0d]: got valid=1 required valid=0 at cycle %0d", i, cyc);
                end else begin
                    m_e = sbq[m_idx];
                    sbq.delete(m_idx);
                    if (m_e.cyc + 1 != cyc || rsp_err[i] !== m_e.err ||
                        rsp_rdata[i*WIDTH +: WIDTH] !== m_e.data) begin
                        n_fail++;
                        $display("FAIL rsp[%0d]: got err=%0b data=0x%h cycle=%0d required err=%0b data=0x%h cycle=%0d",
                                 i, rsp_err[i], rsp_rdata[i*WIDTH +: WIDTH], cyc,
                                 m_e.err, m_e.data, m_e.cyc + 1);
                    end
                end
            end else if (rsp_err[i] !== 1'b0 || rsp_rdata[i*WIDTH +: WIDTH] !== '0) begin
                n_fail++;
                $display("FAIL rsp_idle[%0d]: got err=%0b data=0x%h required err=0 data=0",
                         i, rsp_err[i], rsp_rdata[i*WIDTH +: WIDTH]);
            end
        end
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].cyc + 1 < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_missing[%0d]: got no response required one at cycle %0d",
                         sbq[j].id, sbq[j].cyc + 1);
                sbq.delete(j);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_REQ-1:0] acc;
        int next_a [NUM_REQ];
        int done;
        int guard;

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_data[i] = '0;
            exp_err[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_ram_en", 64'({ram_ena, ram_enb}), 64'(0));
        @(posedge clk); #1;

        // Reset and INIT, request pending during INIT must not be accepted
        rst = 1'b0;
        set_req(0, 1'b0, 32'd3, '0, '0, 1'b0);
        wait_init("init1");

        // Read every address, expecting zeros
        for (int i = 0; i < NUM_REQ; i++) begin
            next_a[i] = i;
            set_req(i, 1'b0, 32'(i), '0, '0, 1'b0);
        end
        done = 0;
        guard = 0;
        while (done < NUM_REQ && guard < 2000) begin
            run_cycle(acc);
            guard++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    next_a[i] += NUM_REQ;
                    if (next_a[i] >= DEPTH) begin
                        req_valid[i] = 1'b0;
                        done++;
                    end else begin
                        set_req(i, 1'b0, 32'(next_a[i]), '0, '0, 1'b0);
                    end
                end
            end
        end
        check("sweep_cycles", 64'(guard), 64'(DEPTH/2));
        idle(2);

        // Write then read-after-write on the next cycle
        set_req(0, 1'b1, 32'd5, 16'hBEEF, 16'hBEEF, 1'b0);
        run_cycle(acc);
        check("t2_write_acc", 64'(acc), 64'(4'b0001));
        req_valid = '0;
        set_req(1, 1'b0, 32'd5, '0, 16'hBEEF, 1'b0);
        run_cycle(acc);
        check("t2_read_acc", 64'(acc), 64'(4'b0010));
        req_valid = '0;
        set_req(3, 1'b0, 32'd100, '0, '0, 1'b0);
        run_cycle(acc);
        check("rr_align1", 64'(acc), 64'(4'b1000));
        req_valid = '0;

        // Same-address write/read conflict with rr=0
        set_req(0, 1'b1, 32'd7, 16'h1111, 16'h1111, 1'b0);
        set_req(1, 1'b0, 32'd7, '0, 16'h1111, 1'b0);
        run_cycle(acc);
        check("t3_conflict", 64'(acc), 64'(4'b0001));
        req_valid[0] = 1'b0;
        run_cycle(acc);
        check("t3_deferred", 64'(acc), 64'(4'b0010));
        req_valid = '0;
        set_req(3, 1'b0, 32'd200, '0, '0, 1'b0);
        run_cycle(acc);
        check("rr_align2", 64'(acc), 64'(4'b1000));
        req_valid = '0;

        // Round-robin with all four continuously reading
        set_req(0, 1'b0, 32'd7, '0, 16'h1111, 1'b0);
        set_req(1, 1'b0, 32'd5, '0, 16'hBEEF, 1'b0);
        set_req(2, 1'b0, 32'd100, '0, '0, 1'b0);
        set_req(3, 1'b0, 32'd300, '0, '0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            run_cycle(acc);
            check($sformatf("t4_rr%0d", c), 64'(acc), (c % 2 == 1) ? 64'(4'b1100) : 64'(4'b0011));
        end
        req_valid = '0;

        // Out-of-range next to the last valid address
        set_req(2, 1'b0, 32'd1024, '0, '0, 1'b1);
        set_req(3, 1'b0, 32'd1023, '0, '0, 1'b0);
        run_cycle(acc);
        check("t5_acc", 64'(acc), 64'(4'b1100));
        check("t5_ena", 64'(s_ena), 64'(0));
        check("t5_portb", 64'({s_enb, s_addrb}), 64'({1'b1, 32'd1023}));
        req_valid = '0;

        // Two writes on both ports, then read back, then two reads of one address
        set_req(0, 1'b1, 32'd10, 16'hAAAA, 16'hAAAA, 1'b0);
        set_req(1, 1'b1, 32'd11, 16'h5555, 16'h5555, 1'b0);
        run_cycle(acc);
        check("dual_write_acc", 64'(acc), 64'(4'b0011));
        check("dual_write_en", 64'({s_ena, s_wea, s_enb, s_web}), 64'(4'hF));
        req_valid = '0;
        set_req(2, 1'b0, 32'd10, '0, 16'hAAAA, 1'b0);
        set_req(3, 1'b0, 32'd11, '0, 16'h5555, 1'b0);
        run_cycle(acc);
        check("dual_read_acc", 64'(acc), 64'(4'b1100));
        req_valid = '0;
        set_req(0, 1'b0, 32'd5, '0, 16'hBEEF, 1'b0);
        set_req(1, 1'b0, 32'd5, '0, 16'hBEEF, 1'b0);
        run_cycle(acc);
        check("same_addr_reads", 64'(acc), 64'(4'b0011));
        idle(2);

        // Reset while a read response is due
        set_req(0, 1'b0, 32'd10, '0, 16'hAAAA, 1'b0);
        run_cycle(acc);
        check("t6_acc", 64'(acc), 64'(4'b0001));
        req_valid = '0;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("t6_drop", 64'(rsp_valid), 64'(0));
        check("t6_ram_en", 64'({ram_ena, ram_enb}), 64'(0));
        check("t6_init_done", 64'(init_done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init("init2");
        set_req(0, 1'b0, 32'd10, '0, '0, 1'b0);
        set_req(1, 1'b0, 32'd5, '0, '0, 1'b0);
        run_cycle(acc);
        check("t6_reread", 64'(acc), 64'(4'b0011));
        idle(3);
        check("sb_empty", 64'(sbq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
